// File: rtl/shift_frame_serializer.sv
// Byte-wide valid/ready source to serial shift-chain writer.
// Words are buffered in a small FIFO and shifted out MSB- or LSB-first, word-aligned.
module shift_frame_serializer #(
  parameter int DATA_W     = 8,
  parameter int FRAME_BITS = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_W-1:0]               s_data,
  input  logic                            start,
  input  logic                            dir_in,
  input  logic                            abort,
  output logic                            sr_en,
  output logic                            sr_din,
  output logic                            sr_dir,
  output logic                            busy,
  output logic                            frame_done,
  output logic [$clog2(FRAME_BITS+1)-1:0] bit_count
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int KW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [KW-1:0] KMAX      = KW'(DATA_W - 1);
  localparam logic [CW-1:0] FRAME_END = CW'(FRAME_BITS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SHIFT, ST_DONE} state_t;

  state_t              state, state_d;
  logic [DATA_W-1:0]   word, word_d;
  logic [KW-1:0]       k, k_d;
  logic [CW-1:0]       bit_count_d;
  logic                sr_dir_d, sr_din_d;
  logic                pop, push, full, empty;
  logic [AW:0]         wr_ptr, rd_ptr;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [DATA_W-1:0]   head;

  // Extra pointer bit distinguishes full from empty.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign s_ready = !full;
  assign push    = s_valid && !full;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  function automatic logic pick(input logic [DATA_W-1:0] w, input logic [KW-1:0] idx,
                                input logic dir);
    return dir ? w[idx] : w[KMAX - idx];
  endfunction

  always_comb begin
    state_d     = state;
    word_d      = word;
    k_d         = k;
    bit_count_d = bit_count;
    sr_dir_d    = sr_dir;
    sr_din_d    = 1'b0;
    pop         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          sr_dir_d    = dir_in;
          bit_count_d = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!empty) begin
          pop      = 1'b1;
          word_d   = head;
          k_d      = '0;
          sr_din_d = pick(head, '0, sr_dir);
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bit_count_d = bit_count + 1'b1;
        if (k == KMAX) begin
          if (bit_count_d == FRAME_END) begin
            state_d = ST_DONE;
          end else if (!empty) begin
            // Back-to-back word: reload without a bubble.
            pop      = 1'b1;
            word_d   = head;
            k_d      = '0;
            sr_din_d = pick(head, '0, sr_dir);
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          k_d      = k + 1'b1;
          sr_din_d = pick(word, k + 1'b1, sr_dir);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) begin
      state_d     = ST_IDLE;
      pop         = 1'b0;
      sr_din_d    = 1'b0;
      bit_count_d = bit_count;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      word       <= '0;
      k          <= '0;
      bit_count  <= '0;
      sr_dir     <= 1'b0;
      sr_din     <= 1'b0;
      sr_en      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      word       <= word_d;
      k          <= k_d;
      bit_count  <= bit_count_d;
      sr_dir     <= sr_dir_d;
      sr_din     <= sr_din_d;
      sr_en      <= (state_d == ST_SHIFT);
      busy       <= (state_d != ST_IDLE);
      frame_done <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_shift_frame_serializer.sv
// Directed bench for shift_frame_serializer: table of whole frames plus
// hand sequences for FIFO-full, start latency, abort and mid-frame reset.
module tb_shift_frame_serializer;
  localparam int FB = 256;
  localparam int CW = 9;

  logic clk = 1'b0;
  logic rst, s_valid, s_ready, start, dir_in, abort;
  logic sr_en, sr_din, sr_dir, busy, frame_done;
  logic [7:0] s_data;
  logic [CW-1:0] bit_count;

  always #5 clk = ~clk;

  shift_frame_serializer #(.DATA_W(8), .FRAME_BITS(FB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .start(start), .dir_in(dir_in), .abort(abort), .sr_en(sr_en), .sr_din(sr_din),
    .sr_dir(sr_dir), .busy(busy), .frame_done(frame_done), .bit_count(bit_count)
  );

  int checks = 0;
  int fails = 0;

  // Chain model and frame statistics, updated on the falling edge.
  logic [FB-1:0] chain;
  logic [7:0]    first8;
  logic [CW-1:0] first_gap_bc;
  int en_cnt, run, max_run, done_cnt, dir_err, gap_cnt, bc_err, first8_n;
  logic mon_clr = 1'b0;
  logic exp_dir = 1'b0;
  logic feed_kill = 1'b0;
  logic feed_active = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      chain <= '0; first8 <= '0; first8_n <= 0; first_gap_bc <= '0;
      en_cnt <= 0; run <= 0; max_run <= 0; done_cnt <= 0;
      dir_err <= 0; gap_cnt <= 0; bc_err <= 0;
    end else begin
      if (sr_en) begin
        if (bit_count != CW'(en_cnt)) bc_err <= bc_err + 1;
        chain <= sr_dir ? {sr_din, chain[FB-1:1]} : {chain[FB-2:0], sr_din};
        if (first8_n < 8) begin
          first8   <= {first8[6:0], sr_din};
          first8_n <= first8_n + 1;
        end
        en_cnt  <= en_cnt + 1;
        run     <= run + 1;
        max_run <= (run + 1 > max_run) ? run + 1 : max_run;
      end else begin
        run <= 0;
        if (busy && en_cnt > 0 && en_cnt < FB) begin
          if (gap_cnt == 0) first_gap_bc <= bit_count;
          gap_cnt <= gap_cnt + 1;
        end
      end
      if (frame_done) done_cnt <= done_cnt + 1;
      if (busy && sr_dir != exp_dir) dir_err <= dir_err + 1;
    end
  end

  task automatic chk(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic feed(input logic [7:0] base, input int first, input int last,
                      input int stall_after, input int stall_len);
    for (int i = first; i <= last; i++) begin
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 3000 && !feed_kill) begin
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = base + 8'(i);
        acc     = s_ready;
        n++;
        @(posedge clk);
      end
      if (!acc && !feed_kill) begin
        checks++; fails++;
        $display("FAIL feed_timeout byte=%0d actual=not_accepted required=accepted", i);
      end
      if (i == stall_after && !feed_kill) begin
        @(negedge clk);
        s_valid = 1'b0;
        repeat (stall_len - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_feed();
    int n;
    n = 0;
    while (feed_active && n < 5000) begin @(negedge clk); n++; end
    chk("feeder_finished", feed_active, 1'b0);
  endtask

  task automatic pulse_start(input logic d);
    @(negedge clk);
    start = 1'b1; dir_in = d;
    @(negedge clk);
    start = 1'b0; dir_in = 1'b0;
  endtask

  task automatic wait_bc(input logic [CW-1:0] target);
    int n;
    n = 0;
    while (bit_count != target && n < 3000) begin @(negedge clk); n++; end
    chk("wait_bit_count", bit_count, target);
  endtask

  task automatic finish_frame(input string tag, input logic [FB-1:0] ec,
                              input logic [7:0] ef8, input int stall);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 4000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_en_cycles"}, en_cnt, FB);
    chk({tag, "_bit_count"}, bit_count, FB);
    chk({tag, "_busy_after"}, busy, 1'b0);
    chk({tag, "_chain"}, chain, ec);
    chk({tag, "_first8"}, first8, ef8);
    chk({tag, "_dir_stable"}, dir_err, 0);
    chk({tag, "_bit_count_track"}, bc_err, 0);
    if (stall < 0) chk({tag, "_consecutive"}, max_run, FB);
    else begin
      chk({tag, "_gap_ge5"}, gap_cnt >= 5, 1'b1);
      chk({tag, "_gap_bit_count"}, first_gap_bc, 88);
    end
  endtask

  typedef struct {
    string         tag;
    logic          dir;
    logic [7:0]    base;
    int            stall_after;
    int            stall_len;
    bit            mid_start;
    logic [FB-1:0] exp_chain;
    logic [7:0]    exp_first8;
  } vec_t;

  vec_t vecs[5];
  logic [FB-1:0] exp_ab;

  initial begin
    vecs[0] = '{"dir0_inc", 1'b0, 8'h00, -1, 0, 1'b0,
      256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f, 8'h00};
    vecs[1] = '{"dir1_inc_midstart", 1'b1, 8'h00, -1, 0, 1'b1,
      256'h1f1e1d1c1b1a19181716151413121110_0f0e0d0c0b0a09080706050403020100, 8'h00};
    vecs[2] = '{"dir1_first01", 1'b1, 8'h01, -1, 0, 1'b0,
      256'h201f1e1d1c1b1a191817161514131211_100f0e0d0c0b0a090807060504030201, 8'h80};
    vecs[3] = '{"dir0_stall", 1'b0, 8'h00, 10, 80, 1'b0,
      256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f, 8'h00};
    vecs[4] = '{"dir0_base80", 1'b0, 8'h80, -1, 0, 1'b0,
      256'h808182838485868788898a8b8c8d8e8f_909192939495969798999a9b9c9d9e9f, 8'h80};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; start = 1'b0; dir_in = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sr_en", sr_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_bit_count", bit_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // FIFO fills while idle; fifth word is held off, then start latency.
    exp_dir = 1'b0;
    clear_mon();
    feed(8'h00, 0, 3, -1, 0);
    chk("full_s_ready", s_ready, 1'b0);
    chk("idle_not_busy", busy, 1'b0);
    s_valid = 1'b1; s_data = 8'h04;
    repeat (3) @(negedge clk);
    chk("held_s_ready", s_ready, 1'b0);
    feed_active = 1'b1;
    fork
      begin feed(8'h00, 4, 31, -1, 0); feed_active = 1'b0; end
    join_none
    pulse_start(1'b0);
    chk("lat_t1_sr_en", sr_en, 1'b0);
    chk("lat_t1_busy", busy, 1'b1);
    @(negedge clk);
    chk("lat_t2_sr_en", sr_en, 1'b1);
    finish_frame("prefill", vecs[0].exp_chain, 8'h00, -1);
    wait_feed();

    for (int v = 0; v < 5; v++) begin
      exp_dir = vecs[v].dir;
      clear_mon();
      feed_active = 1'b1;
      fork
        begin
          feed(vecs[v].base, 0, 31, vecs[v].stall_after, vecs[v].stall_len);
          feed_active = 1'b0;
        end
      join_none
      pulse_start(vecs[v].dir);
      if (vecs[v].mid_start) begin
        wait_bc(9'd50);
        pulse_start(~vecs[v].dir);
      end
      finish_frame(vecs[v].tag, vecs[v].exp_chain, vecs[v].exp_first8, vecs[v].stall_after);
      wait_feed();
    end

    // Abort mid-word; leftover FIFO words lead the next frame.
    exp_dir = 1'b0;
    clear_mon();
    feed_active = 1'b1;
    fork
      begin feed(8'h00, 0, 15, -1, 0); feed_active = 1'b0; end
    join_none
    pulse_start(1'b0);
    wait_bc(9'd100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_sr_en", sr_en, 1'b0);
    chk("abort_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_bits_shifted", en_cnt, 101);
    wait_feed();
    exp_ab = '0;
    exp_ab = {exp_ab[FB-9:0], 8'h0d};
    exp_ab = {exp_ab[FB-9:0], 8'h0e};
    exp_ab = {exp_ab[FB-9:0], 8'h0f};
    for (int j = 0; j < 29; j++) exp_ab = {exp_ab[FB-9:0], 8'h20 + 8'(j)};
    clear_mon();
    feed_active = 1'b1;
    fork
      begin feed(8'h20, 0, 28, -1, 0); feed_active = 1'b0; end
    join_none
    pulse_start(1'b0);
    finish_frame("after_abort", exp_ab, 8'h0d, -1);
    wait_feed();

    // Asynchronous reset mid-shift, then confirm the FIFO was flushed.
    exp_dir = 1'b1;
    clear_mon();
    feed_active = 1'b1;
    fork
      begin feed(8'h00, 0, 31, -1, 0); feed_active = 1'b0; end
    join_none
    pulse_start(1'b1);
    wait_bc(9'd40);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sr_en", sr_en, 1'b0);
    chk("midrst_sr_din", sr_din, 1'b0);
    chk("midrst_sr_dir", sr_dir, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_frame_done", frame_done, 1'b0);
    chk("midrst_bit_count", bit_count, 0);
    chk("midrst_s_ready", s_ready, 1'b1);
    feed_kill = 1'b1;
    wait_feed();
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    feed_kill = 1'b0;
    pulse_start(1'b0);
    repeat (4) @(negedge clk);
    chk("flushed_waiting", busy, 1'b1);
    chk("flushed_no_shift", sr_en, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("flushed_abort_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
